keccak_digest_serializer: RTL

Parametrised successor to the Keccak output buffer. It queues up to DEPTH complete digests from the permutation core and streams each one out as OUT_WIDTH-bit words over a ready/valid interface. Per-digest truncation supports SHA3-224/256/384/512 style output lengths. It sits between the Keccak core's digest output and the narrow host/bus port, and provides full backpressure on both sides.

---
 rtl/keccak_digest_serializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/keccak_digest_serializer.sv
// Digest queue and word serializer for the Keccak permutation core.
// Holds up to DEPTH complete digests and streams each one out as OUT_WIDTH-bit
// words over ready/valid, optionally truncated to a per-digest word count.
//
// state | meaning
// IDLE  | no digest held (count == 0), out_valid low
// SEND  | head digest is being presented word by word (count > 0)
module keccak_digest_serializer #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 64,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1,
  localparam int WORDS    = IN_WIDTH / OUT_WIDTH,
  localparam int WW       = $clog2(WORDS + 1),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [WW-1:0]        in_words,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [CW-1:0]        level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state_q;
  state_t               state_d;
  logic [IN_WIDTH-1:0]  slot_data  [DEPTH];
  logic [WW-1:0]        slot_words [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [WW-1:0]        word_idx;
  logic [WW-1:0]        eff_in;
  logic [IN_WIDTH-1:0]  head_data;
  logic [WW-1:0]        head_words;
  logic [OUT_WIDTH-1:0] word_sel;
  logic                 accept;
  logic                 out_fire;
  logic                 last_fire;

  // Ready is purely a function of occupancy; a draining slot does not free
  // space until the edge after its last word is taken.
  assign in_ready  = (count != CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_fire = out_fire & out_last;
  assign level     = count;

  // Out-of-range word counts (0 or more than a full digest) mean the whole digest;
  // the count is normalised once at accept time so the read side stays simple.
  assign eff_in = ((in_words == '0) || (in_words > WW'(WORDS))) ? WW'(WORDS) : in_words;

  assign head_data  = slot_data[rd_ptr];
  assign head_words = slot_words[rd_ptr];

  // Select word word_idx of the head digest in the configured word order.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (word_idx == WW'(i)) begin
        if (MSB_FIRST != 0) begin
          word_sel = head_data[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
        end else begin
          word_sel = head_data[i*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

  // Slot storage; payload needs no reset because count gates its visibility.
  always_ff @(posedge clock) begin
    if (accept) begin
      slot_data[wr_ptr]  <= in_data;
      slot_words[wr_ptr] <= eff_in;
    end
  end

  // Write/read pointers, occupancy and word index bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_idx <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (last_fire) begin
        rd_ptr   <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        word_idx <= '0;
      end else if (out_fire) begin
        word_idx <= word_idx + WW'(1);
      end
      case ({accept, last_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave SEND only when the final word of the final held
  // digest goes out and nothing new arrives on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (last_fire && (count == CW'(1)) && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; data is forced to zero whenever nothing is offered.
  always_comb begin
    out_valid = (state_q == SEND);
    out_data  = out_valid ? word_sel : '0;
    out_last  = out_valid && (word_idx == (head_words - WW'(1)));
  end

endmodule
